// File: rtl/if_stage.sv
// Instruction fetch stage: a single outstanding imem read, plus an IF/ID pipeline register.
// Handles stall hold, taken-branch flush, and redirect while a read is still in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc, buf_instr, buf_pc, redir;
  logic [31:0] tgt, pc_inc;
  logic        fetch_load, hold_load;

  assign tgt        = br_target & ~32'h3;
  assign pc_inc     = pc + 32'd4;
  assign imem_addr  = pc;
  assign fetch_load = (state == FETCH) && imem_ack;
  assign hold_load  = (state == HOLD);

  // pc stays on the in-flight address until its ack, so imem_addr is stable while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      pc        <= RESET_PC;
      buf_instr <= '0;
      buf_pc    <= '0;
      redir     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            if (br_taken) pc <= tgt;
            else if (stall) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc;
              state     <= HOLD;
              imem_req  <= 1'b0;
            end else pc <= pc_inc;
          end else if (br_taken) begin
            redir <= tgt;
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (br_taken) begin
            buf_instr <= '0;
            buf_pc    <= '0;
            pc        <= tgt;
            state     <= FETCH;
            imem_req  <= 1'b1;
          end else if (!stall) begin
            pc       <= pc_inc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        DRAIN: begin
          // the stale word is thrown away; the newest branch target wins
          if (br_taken) redir <= tgt;
          if (imem_ack) begin
            pc    <= br_taken ? tgt : redir;
            state <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (br_taken) begin
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      if_id_instr <= if_id_instr;
    end else if (fetch_load) begin
      if_id_instr <= imem_rdata;
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
    end else if (hold_load) begin
      if_id_instr <= buf_instr;
      if_id_pc    <= buf_pc;
      if_id_valid <= 1'b1;
    end else begin
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random ack, stall and branch traffic.
// Every cycle is checked against a behavioural fetch model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, stall, br_taken, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, br_target, if_id_instr, if_id_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic        w_ack = 1'b1, w_stall = 1'b0, w_br = 1'b0;
  logic [31:0] w_rdata = 32'h0, w_tgt = 32'h0;

  int n_chk = 0, n_bad = 0;

  // behavioural model: a request is outstanding unless a word is parked waiting on stall
  bit          m_started, m_held, m_drain, m_valid;
  logic [31:0] m_pc, m_rd, m_bw, m_instr, m_ifpc;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid));

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(w_stall), .br_taken(w_br),
    .br_target(w_tgt), .if_id_instr(w_instr), .if_id_pc(w_pc), .if_id_valid(w_valid));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit m_req();
    return m_started && !m_held;
  endfunction

  task automatic m_reset();
    m_started = 0; m_held = 0; m_drain = 0; m_valid = 0;
    m_pc = 32'h0; m_rd = 0; m_bw = 0; m_instr = 0; m_ifpc = 0;
  endtask

  task automatic m_step(input bit a, input bit s, input bit b, input logic [31:0] t,
                        input logic [31:0] d);
    logic [31:0] tt, dw, dp;
    bit deliver;
    tt = {t[31:2], 2'b00};
    deliver = 0; dw = 0; dp = 0;
    if (!m_started) m_started = 1;
    else if (m_held) begin
      if (b) begin m_held = 0; m_pc = tt; end
      else if (!s) begin deliver = 1; dw = m_bw; dp = m_pc; m_held = 0; m_pc = m_pc + 4; end
    end else if (m_drain) begin
      if (b) m_rd = tt;
      if (a) begin m_drain = 0; m_pc = m_rd; end
    end else begin
      if (a && b) m_pc = tt;
      else if (a && s) begin m_held = 1; m_bw = d; end
      else if (a) begin deliver = 1; dw = d; dp = m_pc; m_pc = m_pc + 4; end
      else if (b) begin m_drain = 1; m_rd = tt; end
    end
    if (b) begin m_valid = 0; m_instr = 0; end
    else if (s) ;
    else if (deliver) begin m_valid = 1; m_instr = dw; m_ifpc = dp; end
    else begin m_valid = 0; m_instr = 0; end
  endtask

  // compare at the negedge, drive the next inputs, advance the model one cycle
  task automatic cyc(input bit a, input bit s, input bit b, input logic [31:0] t,
                     input logic [31:0] d);
    chk("req", {31'h0, imem_req}, {31'h0, m_req()});
    chk("addr", imem_addr, m_pc);
    chk("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("instr", if_id_instr, m_instr);
    chk("ifpc", if_id_pc, m_ifpc);
    imem_ack = a; stall = s; br_taken = b; br_target = t; imem_rdata = d;
    m_step(a, s, b, t, d);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 0; stall = 0; br_taken = 0; br_target = 0; imem_rdata = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_ifpc", if_id_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // back-to-back fetch with single-cycle acks
    cyc(0, 0, 0, 0, 0);
    chk("wrap_first", w_addr, 32'hFFFF_FFFC);
    chk("b2b_addr0", imem_addr, 32'h0);
    cyc(1, 0, 0, 0, 32'hE3A0_1001);
    chk("wrap_second", w_addr, 32'h0);
    chk("b2b_addr1", imem_addr, 32'h4);
    chk("b2b_pc0", if_id_pc, 32'h0);
    chk("b2b_v0", {31'h0, if_id_valid}, 32'h1);
    cyc(1, 0, 0, 0, 32'hE281_1001);
    chk("b2b_pc1", if_id_pc, 32'h4);
    chk("b2b_instr1", if_id_instr, 32'hE281_1001);

    // stall as the word at 0x8 lands
    cyc(1, 1, 0, 0, word(32'h8));
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_pc", if_id_pc, 32'h4);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("unhold_pc", if_id_pc, 32'h8);
    chk("unhold_addr", imem_addr, 32'hC);

    // three-cycle ack latency at 0xC
    cyc(0, 0, 0, 0, 0);
    chk("lat_addr", imem_addr, 32'hC);
    chk("lat_bubble", {31'h0, if_id_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, word(32'hC));
    chk("lat_pc", if_id_pc, 32'hC);
    chk("lat_addr2", imem_addr, 32'h10);

    // redirect while 0x10 is outstanding
    cyc(0, 0, 1, 32'h103, 0);
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_valid", {31'h0, if_id_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, word(32'h10));
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h0);

    // branch and stall together
    cyc(0, 1, 1, 32'h200, 0);
    chk("brst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("brst_instr", if_id_instr, 32'h0);
    cyc(1, 0, 0, 0, word(32'h100));
    chk("brst_addr", imem_addr, 32'h200);
    cyc(1, 1, 1, 32'h300, word(32'h200));

    for (int i = 0; i < 2000; i++) begin
      bit a, s, b;
      a = m_req() && ($urandom_range(1, 0) == 1);
      s = ($urandom_range(3, 0) == 0);
      b = ($urandom_range(7, 0) == 0);
      cyc(a, s, b, $urandom, word(m_pc));
    end

    // settle into plain FETCH, then reset in the middle of a drain
    for (int i = 0; i < 20 && (m_held || m_drain); i++) cyc(m_req(), 0, 0, 0, word(m_pc));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0);
    imem_ack = 0; stall = 0; br_taken = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("mid_rst_instr", if_id_instr, 32'h0);
    chk("mid_rst_ifpc", if_id_pc, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 32'hDEAD_BEEF);
    chk("refetch_addr", imem_addr, 32'h0);
    for (int i = 0; i < 200; i++) begin
      bit a;
      a = m_req() && ($urandom_range(1, 0) == 1);
      cyc(a, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0, $urandom, word(m_pc));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
